am_envelope_detector: RTL and testbench

Non-coherent AM demodulator stage that consumes the Q2.FW modulated stream produced by the AM modulator. It full-wave rectifies each sample, averages over a fixed decimation window with an integrate-and-dump, and optionally subtracts a slowly tracked DC (carrier) level. Output is a decimated envelope with a one-cycle valid strobe, feeding the baseband recovery/compare logic.

---
 rtl/am_pkg.sv | 29 ++
 rtl/am_int_dump.sv | 64 ++++++
 rtl/am_envelope_detector.sv | 103 ++++++++++
 tb/tb_am_envelope_detector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// Shared helpers for the AM modulator/demodulator pair: fraction-width
// derivation, log2 for window sizing and saturating absolute value.
package am_pkg;

  // Fraction bits of a Q2.FW sample whose magnitude part is w bits wide.
  function automatic int unsigned fw_of(input int unsigned w);
    return w - 1;
  endfunction

  // Number of bits needed to count n samples (n is a power of two).
  function automatic int unsigned log2_of(input int unsigned n);
    return $clog2(n);
  endfunction

  // |x| clamped to w unsigned bits; the most negative input would otherwise
  // need one more bit, so it saturates to 2^w-1.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                          input int unsigned     w);
    logic [31:0] lim;
    logic [31:0] mag;
    lim = (32'd1 << w) - 32'd1;
    mag = (x < 0) ? 32'(-x) : 32'(x);
    if (mag > lim) begin
      mag = lim;
    end
    return mag;
  endfunction

endpackage

// File: rtl/am_int_dump.sv
// Integrate-and-dump over DEC rectified samples. Emits the truncated window
// mean with a one-cycle strobe; a partial window survives gaps in the input.
import am_pkg::*;

module am_int_dump #(
  parameter int W   = 12,
  parameter int DEC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rect_i,
  input  logic         rect_v_i,
  output logic [W-1:0] mean_o,
  output logic         mean_v_o
);

  localparam int LG = int'(log2_of(DEC));
  localparam int AW = W + LG;

  logic [AW-1:0] acc_q, acc_d;
  logic [LG-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mean_q, mean_d;
  logic          mean_v_q, mean_v_d;
  logic [AW-1:0] sum;

  // Accumulate each valid sample; on the last one of the window dump the mean.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mean_d   = mean_q;
    mean_v_d = 1'b0;
    sum      = acc_q + {{LG{1'b0}}, rect_i};
    if (rect_v_i) begin
      if (cnt_q != LG'(DEC - 1)) begin
        acc_d = sum;
        cnt_d = cnt_q + LG'(1);
      end else begin
        mean_d   = sum[AW-1:LG];
        acc_d    = '0;
        cnt_d    = '0;
        mean_v_d = 1'b1;
      end
    end
  end

  // Window state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      mean_q   <= '0;
      mean_v_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mean_q   <= mean_d;
      mean_v_q <= mean_v_d;
    end
  end

  assign mean_o   = mean_q;
  assign mean_v_o = mean_v_q;

endmodule

// File: rtl/am_envelope_detector.sv
// Non-coherent AM envelope detector: full-wave rectify, integrate-and-dump
// decimation, optional subtraction of a leaky-integrator DC (carrier) level.
import am_pkg::*;

module am_envelope_detector #(
  parameter int W        = 12,
  parameter int DEC      = 16,
  parameter int DC_SHIFT = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic signed [W:0]   modin,
  input  logic                dc_remove,
  output logic signed [W:0]   env_out,
  output logic                out_valid
);

  localparam int DW = W + DC_SHIFT;

  // Stage 1: rectifier
  logic [W-1:0] rect_q, rect_d;
  logic         rect_v_q;

  // Magnitude of the incoming sample; only loaded when a sample arrives.
  always_comb begin
    rect_d = rect_q;
    if (en) begin
      rect_d = W'(sat_abs(32'(modin), W));
    end
  end

  // Rectifier registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rect_q   <= '0;
      rect_v_q <= 1'b0;
    end else begin
      rect_q   <= rect_d;
      rect_v_q <= en;
    end
  end

  // Stage 2: integrate-and-dump
  logic [W-1:0] mean_q;
  logic         mean_v_q;

  am_int_dump #(
    .W   (W),
    .DEC (DEC)
  ) u_int_dump (
    .clk      (clk),
    .rst_n    (rst_n),
    .rect_i   (rect_q),
    .rect_v_i (rect_v_q),
    .mean_o   (mean_q),
    .mean_v_o (mean_v_q)
  );

  // Stage 3: DC tracking and output
  logic [DW-1:0]        dc_int_q, dc_int_d;
  logic [W-1:0]         dc;
  logic signed [DW+1:0] dc_diff;
  logic signed [DW+1:0] dc_step;
  logic signed [DW+1:0] dc_sum;
  logic signed [W:0]    env_q, env_d;
  logic                 out_valid_q;

  assign dc = dc_int_q[DW-1:DC_SHIFT];

  // Output uses the DC estimate from before this window's tracker update;
  // the tracker moves 2^-K of the way toward the new mean every window.
  always_comb begin
    dc_int_d = dc_int_q;
    env_d    = env_q;
    dc_diff  = $signed({2'b00, mean_q, {DC_SHIFT{1'b0}}})
             - $signed({2'b00, dc_int_q});
    dc_step  = dc_diff >>> DC_SHIFT;
    dc_sum   = $signed({2'b00, dc_int_q}) + dc_step;
    if (mean_v_q) begin
      env_d    = dc_remove ? ($signed({1'b0, mean_q}) - $signed({1'b0, dc}))
                           : $signed({1'b0, mean_q});
      dc_int_d = DW'(dc_sum);
    end
  end

  // Output and DC estimate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_int_q    <= '0;
      env_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dc_int_q    <= dc_int_d;
      env_q       <= env_d;
      out_valid_q <= mean_v_q;
    end
  end

  assign env_out   = env_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_am_envelope_detector.sv
// Scoreboard bench for am_envelope_detector: a sample-level reference model
// predicts each envelope value and the edge it must appear on.
module tb_am_envelope_detector;

  localparam int W   = 12;
  localparam int DEC = 16;
  localparam int K   = 6;
  localparam int MAXMAG = (1 << W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic signed [W:0]   modin = '0;
  logic                dc_remove = 1'b0;
  logic signed [W:0]   env_out;
  logic                out_valid;

  am_envelope_detector #(.W(W), .DEC(DEC), .DC_SHIFT(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .modin     (modin),
    .dc_remove (dc_remove),
    .env_out   (env_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct { int env; int cyc; } exp_t;
  exp_t sb[$];
  int   obs_env[$];
  int   obs_cyc[$];

  // Reference model state
  int m_acc = 0;
  int m_cnt = 0;
  int m_dc  = 0;

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_dc  = 0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus (at the falling edge) and update the model.
  task automatic step(input logic e, input int m, input logic dcr);
    int a;
    int mean;
    int env;
    exp_t x;
    en        = e;
    modin     = (W+1)'(m);
    dc_remove = dcr;
    if (e) begin
      a = (m < 0) ? -m : m;
      if (a > MAXMAG) a = MAXMAG;
      m_acc += a;
      m_cnt++;
      if (m_cnt == DEC) begin
        mean  = m_acc / DEC;
        env   = dcr ? mean - (m_dc / (1 << K)) : mean;
        m_dc  = m_dc + ((mean * (1 << K) - m_dc) >>> K);
        x.env = env;
        x.cyc = cyc + 3;
        sb.push_back(x);
        m_acc = 0;
        m_cnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic dcr);
    for (int i = 0; i < n; i++) step(1'b0, 0, dcr);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ov", int'(out_valid), 0);
    chk("async_rst_env", int'(env_out), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents a result.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        chk("ov_single_cycle", int'(prev_ov), 0);
        obs_env.push_back(int'(env_out));
        obs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("env", int'(env_out), x.env);
          chk("out_edge", cyc, x.cyc);
        end
      end
      prev_ov = out_valid;
    end
  end

  int start;

  initial begin
    // Reset held with activity on the inputs
    en    = 1'b1;
    modin = 13'sd1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_ov", int'(out_valid), 0);
      chk("rst_env", int'(env_out), 0);
    end
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Constant +1024, raw mean
    obs_env.delete(); obs_cyc.delete();
    start = cyc;
    for (int i = 0; i < 3 * DEC; i++) step(1'b1, 1024, 1'b0);
    idle(4, 1'b0);
    chk("const_count", obs_env.size(), 3);
    if (obs_env.size() >= 3) begin
      chk("const_first_edge", obs_cyc[0] - start, 18);
      chk("const_period", obs_cyc[1] - obs_cyc[0], DEC);
      chk("const_val", obs_env[2], 1024);
    end

    // Alternating polarity
    obs_env.delete(); obs_cyc.delete();
    for (int i = 0; i < 2 * DEC; i++) step(1'b1, (i % 2) ? -1024 : 1024, 1'b0);
    idle(4, 1'b0);
    chk("alt_count", obs_env.size(), 2);
    if (obs_env.size() >= 1) chk("alt_val", obs_env[0], 1024);

    // Most negative input saturates to the largest magnitude
    obs_env.delete(); obs_cyc.delete();
    for (int i = 0; i < DEC; i++) step(1'b1, -4096, 1'b0);
    idle(4, 1'b0);
    chk("sat_count", obs_env.size(), 1);
    if (obs_env.size() >= 1) chk("sat_val", obs_env[0], MAXMAG);

    // DC removal from a fresh DC estimate
    pulse_reset();
    obs_env.delete(); obs_cyc.delete();
    for (int i = 0; i < 6 * DEC; i++) step(1'b1, 1024, 1'b1);
    idle(4, 1'b1);
    chk("dc_count", obs_env.size(), 6);
    if (obs_env.size() >= 6) begin
      chk("dc_first", obs_env[0], 1024);
      chk("dc_second", obs_env[1], 1008);
      for (int i = 1; i < 6; i++) begin
        chk("dc_decreasing", int'(obs_env[i] < obs_env[i-1]), 1);
        chk("dc_nonneg", int'(obs_env[i] >= 0), 1);
      end
    end
    idle(2, 1'b0);

    // Sample strobe every other cycle
    obs_env.delete(); obs_cyc.delete();
    for (int i = 0; i < 2 * DEC; i++) begin
      step(1'b1, 512, 1'b0);
      step(1'b0, 0, 1'b0);
    end
    idle(4, 1'b0);
    chk("gap_count", obs_env.size(), 2);
    if (obs_env.size() >= 2) begin
      chk("gap_val", obs_env[1], 512);
      chk("gap_period", obs_cyc[1] - obs_cyc[0], 2 * DEC);
    end

    // Partial window discarded by reset
    obs_env.delete(); obs_cyc.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 2000, 1'b0);
    chk("partial_no_out", obs_env.size(), 0);
    pulse_reset();
    for (int i = 0; i < DEC; i++) step(1'b1, 512, 1'b0);
    idle(4, 1'b0);
    chk("post_rst_count", obs_env.size(), 1);
    if (obs_env.size() >= 1) chk("post_rst_val", obs_env[0], 512);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
